axis_rx_fifo: RTL
=================

// Module: axis_rx_fifo
// PURPOSE
//  AXI-Stream receive endpoint with packet framing check. Accepts beats from an
//  AXI-Stream data generator (8-beat packets, tlast on beat 7) into a FIFO.
//  The FIFO is drained through a first-word-fall-through read port.
//  Checks every packet length against PKT_LEN and counts packets and framing errors.
// PARAMETERS
//  DATA_W   8   tdata / rd_data width
//  DEPTH    16  FIFO entries; power of two, >=2
//  PKT_LEN  8   expected beats per packet (tlast on beat PKT_LEN-1); >=1
// PORTS
//  clk        in   1                 rising-edge clock
//  resetn     in   1                 asynchronous active-low reset
//  tvalid     in   1                 stream beat valid
//  tdata      in   DATA_W            stream beat data
//  tlast      in   1                 last beat of packet
//  tready     out  1                 FIFO can accept a beat
//  rd_en      in   1                 pop head entry (ignored when rd_valid=0)
//  rd_valid   out  1                 FIFO not empty; rd_data/rd_last valid
//  rd_data    out  DATA_W            head entry data (FWFT)
//  rd_last    out  1                 head entry tlast
//  level      out  $clog2(DEPTH+1)   entries currently stored
//  pkt_count  out  8                 accepted tlast beats, wraps 255->0
//  err_count  out  8                 framing errors, saturates at 255
//  len_err    out  1                 one-cycle pulse per framing error
// BEHAVIOUR
//  Reset (async, resetn=0): FIFO empty, level=0, rd_valid=0, tready=1,
//   pkt_count=0, err_count=0, len_err=0, beat counter=0.
//   Takes effect immediately, including mid-packet. Buffered data is discarded.
//  tready = (level < DEPTH), combinational from registered level.
//   tready does not depend on tvalid or rd_en.
//  Push: a beat is accepted on a rising edge when tvalid && tready.
//   {tlast,tdata} is written at the tail.
//  Pop: occurs when rd_en && rd_valid; the head advances.
//   rd_data/rd_last show the new head the next cycle.
//  rd_valid = (level != 0). rd_data/rd_last are driven from the head entry with
//   no read latency. Their value is don't-care when rd_valid=0.
//  Simultaneous push+pop: level unchanged, order preserved.
//   Push when full: not possible, since tready=0. Pop when empty: ignored.
//  Pointers: log2(DEPTH) bits, wrap naturally modulo DEPTH.
//  Framing: beat counter bc (0..PKT_LEN-1) advances on each accepted beat.
//   - tlast=1, bc==PKT_LEN-1: good packet, bc->0
//   - tlast=1, bc!=PKT_LEN-1: short packet, error, bc->0
//   - tlast=0, bc==PKT_LEN-1: long packet, error, bc->0 (boundary forced)
//   - otherwise: bc->bc+1
//   Beats are stored regardless of error.
//   pkt_count increments on every accepted tlast beat.
//  On an error: len_err=1 for exactly the following cycle (registered), and
//   err_count += 1 unless it is already 255.
//  Latency: an accepted beat is visible on rd_* one cycle after its accept edge.
// TESTING
//  T1 reset: resetn low 3 cycles -> tready=1, rd_valid=0, level=0,
//     pkt_count=0, err_count=0.
//  T2 one packet: push 0..7 with tlast on 7, rd_en=0 -> level=8, pkt_count=1,
//     len_err never 1. Then rd_en=1 -> rd_data 0..7, rd_last=1 only with 7.
//  T3 full: push 16 beats, no reads -> level=16, tready=0. A 17th beat (0xAA)
//     held with tvalid=1 is not accepted. One pop -> tready=1 next cycle and
//     0xAA is accepted.
//  T4 framing errors: tlast on beat 4 -> len_err pulse, err_count=1, pkt_count=1.
//     Then 8 beats with no tlast -> len_err after beat 7, err_count=2.
//  T5 push+pop: at level=5, push and pop in the same cycle for 10 cycles ->
//     level stays 5; read order equals write order.
//  T6 reset mid-packet: 3 beats, resetn pulse -> level=0. Next packet 0..7 with
//     tlast -> no len_err, pkt_count=1.

Source files
------------

// File: rtl/axis_rx_fifo.sv
// rtl/axis_rx_fifo.sv - AXI-Stream receive FIFO with FWFT read port and packet framing check
module axis_rx_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int PKT_LEN = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       tvalid,
    input  logic [DATA_W-1:0]          tdata,
    input  logic                       tlast,
    output logic                       tready,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_last,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [7:0]                 pkt_count,
    output logic [7:0]                 err_count,
    output logic                       len_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [BW-1:0] BC_LAST    = BW'(PKT_LEN-1);

    logic [DATA_W:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [BW-1:0] bc_q, bc_d;
    logic [7:0]    pkt_count_q, pkt_count_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          len_err_q, len_err_d;

    logic push, pop, frame_err;

    assign tready    = (level_q < FULL_LEVEL);
    assign rd_valid  = (level_q != '0);
    assign rd_data   = mem_q[rd_ptr_q][DATA_W-1:0];
    assign rd_last   = mem_q[rd_ptr_q][DATA_W];
    assign level     = level_q;
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
    assign len_err   = len_err_q;

    assign push = tvalid && tready;
    assign pop  = rd_en && rd_valid;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        bc_d        = bc_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        frame_err   = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        // Packet boundary is forced at PKT_LEN beats even without tlast.
        if (push) begin
            if (tlast) begin
                pkt_count_d = pkt_count_q + 8'd1;
                frame_err   = (bc_q != BC_LAST);
                bc_d        = '0;
            end else if (bc_q == BC_LAST) begin
                frame_err = 1'b1;
                bc_d      = '0;
            end else begin
                bc_d = bc_q + BW'(1);
            end
        end

        if (frame_err && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
        len_err_d = frame_err;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            bc_q        <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            bc_q        <= bc_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
            len_err_q   <= len_err_d;
        end
    end

    // Storage needs no reset: entries are only observed while rd_valid=1.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {tlast, tdata};
        end
    end

endmodule
